// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm-clock button input path.
// Holds the per-button FSM states, default timing and the counter-width helper.
package clock_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms, 500 ms and 100 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int REPEAT_DELAY_DEF    = 50_000_000;
  localparam int REPEAT_PERIOD_DEF   = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, stability counter and press/hold/release FSM.
// All outputs registered; press latency is DEBOUNCE_CYCLES + 2 edges from the first high sample.
module debounce_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_step
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] C_DEB    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_DLY_M1 = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_PER_M1 = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first_done;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_step;

  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_first_nxt;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_step_nxt;
  logic             w_rep_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Saturating increment keeps a stuck state from wrapping into a false match
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + C_ONE;
  assign w_rep_hit = r_first_done ? (r_cnt >= C_PER_M1) : (r_cnt >= C_DLY_M1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_first_nxt   = r_first_done;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_step_nxt    = 1'b0;

    case (r_state)
      RELEASED: begin
        w_level_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (r_sync2) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = C_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= C_DEB) begin
          w_state_nxt = HELD;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_step_nxt  = 1'b1;
          w_first_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      HELD: begin
        w_level_nxt = 1'b1;
        if (!r_sync2) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = C_ONE;
        end else if (w_rep_hit) begin
          w_step_nxt  = 1'b1;
          w_first_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      RELEASE_WAIT: begin
        // A bounce back to high restarts the whole repeat interval
        if (r_sync2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= C_DEB) begin
          w_state_nxt   = RELEASED;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
          w_first_nxt   = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      default: begin
        w_state_nxt = RELEASED;
        w_level_nxt = 1'b0;
        w_first_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= RELEASED;
      r_cnt        <= '0;
      r_first_done <= 1'b0;
      r_level      <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_step       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_first_done <= w_first_nxt;
      r_level      <= w_level_nxt;
      r_press      <= w_press_nxt;
      r_release    <= w_release_nxt;
      r_step       <= w_step_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_step    = r_step;

endmodule

// File: rtl/button_reader.sv
// Debounced levels, press/release pulses and auto-repeat steps for N_BTN raw buttons.
// Channels are fully independent; each is one debounce_channel instance.
module button_reader
  import clock_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_raw     (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_step    (btn_step[g])
    );
  end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed scenarios then random bouncing buttons,
// every cycle compared against a run-length reference model of the button rules.
module tb_button_reader;

  localparam int NB  = 5;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_step;

  button_reader #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_step    (btn_step)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a button sample stream delayed two edges, judged by run lengths
  logic [NB-1:0] dly1, dly2;
  bit            run_val [NB];
  int            run_len [NB];
  int            anchor  [NB];
  bit            lvl     [NB];
  bit            fdone   [NB];
  int            n_edge;
  logic [NB-1:0] e_lvl, e_prs, e_rel, e_stp;

  task automatic model_reset();
    dly1 = '0;
    dly2 = '0;
    for (int c = 0; c < NB; c++) begin
      run_val[c] = 1'b0;
      run_len[c] = 0;
      anchor[c]  = 0;
      lvl[c]     = 1'b0;
      fdone[c]   = 1'b0;
    end
    e_lvl = '0;
    e_prs = '0;
    e_rel = '0;
    e_stp = '0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] v;
    v    = dly2;
    dly2 = dly1;
    dly1 = btn_raw;
    e_prs = '0;
    e_rel = '0;
    e_stp = '0;
    for (int c = 0; c < NB; c++) begin
      if (v[c] == run_val[c]) run_len[c]++;
      else begin
        run_val[c] = v[c];
        run_len[c] = 1;
      end
      if (!lvl[c]) begin
        if (v[c] && run_len[c] >= DEB + 1) begin
          lvl[c] = 1'b1; e_prs[c] = 1'b1; e_stp[c] = 1'b1;
          anchor[c] = n_edge; fdone[c] = 1'b0;
        end
      end else if (!v[c]) begin
        if (run_len[c] >= DEB + 1) begin
          lvl[c] = 1'b0; e_rel[c] = 1'b1; fdone[c] = 1'b0;
        end
      end else if (run_len[c] == 1) begin
        anchor[c] = n_edge;
      end else if (n_edge - anchor[c] == (fdone[c] ? RP : RD)) begin
        e_stp[c] = 1'b1; anchor[c] = n_edge; fdone[c] = 1'b1;
      end
      e_lvl[c] = lvl[c];
    end
    n_edge++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_eq("level",   int'(btn_level),   int'(e_lvl));
    check_eq("press",   int'(btn_press),   int'(e_prs));
    check_eq("release", int'(btn_release), int'(e_rel));
    check_eq("step",    int'(btn_step),    int'(e_stp));
  endtask

  task automatic cycle(input logic [NB-1:0] raw);
    btn_raw = raw;
    tick();
  endtask

  task automatic hold_until_press(input logic [NB-1:0] raw, input logic [NB-1:0] want,
                                  output int ticks);
    int k;
    ticks = -1;
    k = 0;
    while (ticks < 0 && k < 40) begin
      k++;
      cycle(raw);
      if (btn_press == want) ticks = k;
    end
  endtask

  // Asynchronous reset asserted between clock edges; rst stays high for the caller
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq({tag, "_level"},   int'(btn_level),   0);
    check_eq({tag, "_press"},   int'(btn_press),   0);
    check_eq({tag, "_release"}, int'(btn_release), 0);
    check_eq({tag, "_step"},    int'(btn_step),    0);
  endtask

  logic [NB-1:0] pat_bounce_press   [8];
  logic [NB-1:0] pat_bounce_release [12];
  logic [NB-1:0] tgt, raw;
  int            lat;

  initial begin
    n_edge  = 0;
    btn_raw = '0;
    rst     = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst0_level",   int'(btn_level),   0);
    check_eq("rst0_press",   int'(btn_press),   0);
    check_eq("rst0_release", int'(btn_release), 0);
    check_eq("rst0_step",    int'(btn_step),    0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) cycle('0);

    // Clean press on bit 0, then hold long enough to see repeats
    hold_until_press(5'b00001, 5'b00001, lat);
    check_eq("press_lat_bit0", lat, DEB + 3);
    repeat (30) cycle(5'b00001);
    repeat (10) cycle('0);

    // Bouncy press on bit 1
    pat_bounce_press = '{5'h2, 5'h2, 5'h0, 5'h2, 5'h2, 5'h2, 5'h2, 5'h2};
    for (int i = 0; i < 8; i++) cycle(pat_bounce_press[i]);
    repeat (12) cycle(5'b00010);
    repeat (10) cycle('0);

    // Auto-repeat on bit 2
    repeat (45) cycle(5'b00100);
    repeat (10) cycle('0);

    // Release with a bounce on bit 3
    repeat (12) cycle(5'b01000);
    pat_bounce_release = '{5'h0, 5'h0, 5'h8, 5'h0, 5'h0, 5'h0, 5'h0,
                           5'h0, 5'h0, 5'h0, 5'h0, 5'h0};
    for (int i = 0; i < 12; i++) cycle(pat_bounce_release[i]);

    // Simultaneous press on every bit
    hold_until_press(5'h1f, 5'h1f, lat);
    check_eq("press_lat_all", lat, DEB + 3);
    repeat (4) cycle(5'h1f);

    // Reset while held; press must be re-reported with full latency
    check_eq("held_before_rst", int'(btn_level[0]), 1);
    mid_reset("rst_hold");
    cycle(5'h1f);
    rst = 1'b0;
    hold_until_press(5'h1f, 5'h1f, lat);
    check_eq("press_lat_after_rst", lat, DEB + 3);
    repeat (10) cycle('0);

    // Random bouncing buttons with long holds and occasional resets
    tgt = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 59) == 0) tgt[c] = ~tgt[c];
        raw[c] = tgt[c] ^ ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 1499) == 0) mid_reset("rst_rand");
      cycle(raw);
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
